// File: rtl/input_cond.sv
// Per-channel input conditioning: two-flop synchroniser, tick-counted debouncer,
// registered edge pulses and sticky event flags, all on a single system clock.
module input_cond #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CNT_W    = 4,
  parameter int unsigned      DEBOUNCE = 10,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int unsigned      EVT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  output logic             any_evt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic [WIDTH-1:0] set;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             any_q, any_d;

  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != dout_q[i]) begin
        if (!tick) begin
          cnt_d[i] = cnt_q[i];
        end else if (cnt_q[i] == CntMax) begin
          dout_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d = ~dout_q & dout_d;
    fall_d = dout_q & ~dout_d;
    if (EVT_MODE == 0) begin
      set = rise_d;
    end else if (EVT_MODE == 1) begin
      set = fall_d;
    end else begin
      set = rise_d | fall_d;
    end
    // A set in the same cycle as a clear wins.
    evt_d = set | (evt_q & ~clr);
    any_d = |evt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= INIT;
      s2_q   <= INIT;
      dout_q <= INIT;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      any_q  <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign evt     = evt_q;
  assign any_evt = any_q;

endmodule

// File: tb/tb_input_cond.sv
// Bench for input_cond: three instances (both-edge and rise-only events, plus a
// DEBOUNCE=1 / INIT=FF fall-event instance) driven from a per-cycle expectation queue.
module tb_input_cond;

  localparam int TickPer = 5;

  logic       clk;
  logic       reset, reset_c;
  logic       tick;
  logic [3:0] din, clr;
  logic [7:0] din_c, clr_c;

  logic [3:0] a_dout, a_rise, a_fall, a_evt;
  logic [3:0] b_dout, b_rise, b_fall, b_evt;
  logic [7:0] c_dout, c_rise, c_fall, c_evt;
  logic       a_any, b_any, c_any;
  logic [66:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        tick;
    logic [3:0]  din;
    logic [3:0]  clr;
    logic        chk;
    logic [66:0] exp;
  } ent_t;

  ent_t q[$];

  input_cond #(.WIDTH(4), .CNT_W(4), .DEBOUNCE(3), .INIT(4'h0), .EVT_MODE(2)) u_a (
    .clk(clk), .reset(reset), .tick(tick), .din(din), .clr(clr),
    .dout(a_dout), .rise(a_rise), .fall(a_fall), .evt(a_evt), .any_evt(a_any)
  );

  input_cond #(.WIDTH(4), .CNT_W(4), .DEBOUNCE(3), .INIT(4'h0), .EVT_MODE(0)) u_b (
    .clk(clk), .reset(reset), .tick(tick), .din(din), .clr(clr),
    .dout(b_dout), .rise(b_rise), .fall(b_fall), .evt(b_evt), .any_evt(b_any)
  );

  input_cond #(.WIDTH(8), .CNT_W(4), .DEBOUNCE(1), .INIT(8'hFF), .EVT_MODE(1)) u_c (
    .clk(clk), .reset(reset_c), .tick(tick), .din(din_c), .clr(clr_c),
    .dout(c_dout), .rise(c_rise), .fall(c_fall), .evt(c_evt), .any_evt(c_any)
  );

  assign obs = {a_dout, a_rise, a_fall, a_evt, a_any,
                b_dout, b_rise, b_fall, b_evt, b_any,
                c_dout, c_rise, c_fall, c_evt, c_any};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] o4(input logic [3:0] d, r, f, e);
    return {d, r, f, e, |e};
  endfunction

  function automatic logic [32:0] o8(input logic [7:0] d, r, f, e);
    return {d, r, f, e, |e};
  endfunction

  // Expectation for A and B while C is still held in reset.
  function automatic logic [66:0] ab(input logic [16:0] a, b);
    return {a, b, o8(8'hFF, 8'h00, 8'h00, 8'h00)};
  endfunction

  task automatic push(input logic t, input logic [3:0] d, c, input logic chk,
                      input logic [66:0] exp);
    q.push_back('{t, d, c, chk, exp});
  endtask

  // One sample period: idle cycles then a tick cycle, which is always checked.
  task automatic push_period(input logic [3:0] d, c, input logic chk_idle,
                             input logic [66:0] exp);
    for (int k = 0; k < TickPer - 1; k++) q.push_back('{1'b0, d, 4'h0, chk_idle, exp});
    q.push_back('{1'b1, d, c, 1'b1, exp});
  endtask

  task automatic test_reset();
    din = 4'hF;
    @(negedge clk);
    checks++;
    if (obs !== ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0))) begin
      errors++;
      $display("FAIL reset_hold1 got %h exp %h", obs, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0))) begin
      errors++;
      $display("FAIL reset_hold3 got %h exp %h", obs, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    end
    din   = 4'h0;
    reset = 1'b1;
  endtask

  task automatic test_clean_press();
    ent_t e;
    int   n = 0;
    push(1'b0, 4'b0001, 4'h0, 1'b1, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    push(1'b0, 4'b0001, 4'h0, 1'b1, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    push_period(4'b0001, 4'h0, 1'b0, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    push_period(4'b0001, 4'h0, 1'b0, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
    push_period(4'b0001, 4'h0, 1'b0,
                ab(o4(4'b0001, 4'b0001, 0, 4'b0001), o4(4'b0001, 4'b0001, 0, 4'b0001)));
    push(1'b0, 4'b0001, 4'h0, 1'b1, ab(o4(4'b0001, 0, 0, 4'b0001), o4(4'b0001, 0, 0, 4'b0001)));
    while (q.size() != 0) begin
      e = q.pop_front();
      tick = e.tick; din = e.din; clr = e.clr;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (e.chk) begin
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL clean_press cyc%0d got %h exp %h", n, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_bounce();
    ent_t        e;
    int          n = 0;
    logic [3:0]  pat [7];
    logic [66:0] s;
    pat = '{4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0001};
    s   = ab(o4(4'b0001, 0, 0, 4'b0001), o4(4'b0001, 0, 0, 4'b0001));
    foreach (pat[k]) push_period(pat[k], 4'h0, 1'b0, s);
    while (q.size() != 0) begin
      e = q.pop_front();
      tick = e.tick; din = e.din; clr = e.clr;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (e.chk) begin
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL bounce cyc%0d got %h exp %h", n, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_release();
    ent_t e;
    int   n = 0;
    push(1'b0, 4'b0001, 4'b0001, 1'b1, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    push_period(4'b0000, 4'h0, 1'b0, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    push_period(4'b0000, 4'h0, 1'b0, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    push_period(4'b0000, 4'h0, 1'b0,
                ab(o4(0, 0, 4'b0001, 4'b0001), o4(0, 0, 4'b0001, 0)));
    push(1'b0, 4'b0000, 4'h0, 1'b1, ab(o4(0, 0, 0, 4'b0001), o4(0, 0, 0, 0)));
    while (q.size() != 0) begin
      e = q.pop_front();
      tick = e.tick; din = e.din; clr = e.clr;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (e.chk) begin
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL release cyc%0d got %h exp %h", n, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_clr_collision();
    ent_t e;
    int   n = 0;
    push_period(4'b0001, 4'h0, 1'b0, ab(o4(0, 0, 0, 4'b0001), o4(0, 0, 0, 0)));
    push_period(4'b0001, 4'h0, 1'b0, ab(o4(0, 0, 0, 4'b0001), o4(0, 0, 0, 0)));
    push_period(4'b0001, 4'b0001, 1'b0,
                ab(o4(4'b0001, 4'b0001, 0, 4'b0001), o4(4'b0001, 4'b0001, 0, 4'b0001)));
    push(1'b0, 4'b0001, 4'b0001, 1'b1, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    while (q.size() != 0) begin
      e = q.pop_front();
      tick = e.tick; din = e.din; clr = e.clr;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (e.chk) begin
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL clr_collision cyc%0d got %h exp %h", n, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ent_t e;
    int   n = 0;
    push_period(4'b1011, 4'h0, 1'b0, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    push_period(4'b1011, 4'h0, 1'b0, ab(o4(4'b0001, 0, 0, 0), o4(4'b0001, 0, 0, 0)));
    push_period(4'b1011, 4'h0, 1'b0,
                ab(o4(4'b1011, 4'b1010, 0, 4'b1010), o4(4'b1011, 4'b1010, 0, 4'b1010)));
    // Channel 2 left mid-debounce with two ticks counted.
    push_period(4'b1111, 4'h0, 1'b0, ab(o4(4'b1011, 0, 0, 4'b1010), o4(4'b1011, 0, 0, 4'b1010)));
    push_period(4'b1111, 4'h0, 1'b0, ab(o4(4'b1011, 0, 0, 4'b1010), o4(4'b1011, 0, 0, 4'b1010)));
    for (int pass = 0; pass < 2; pass++) begin
      while (q.size() != 0) begin
        e = q.pop_front();
        tick = e.tick; din = e.din; clr = e.clr;
        @(posedge clk);
        @(negedge clk);
        n++;
        if (e.chk) begin
          checks++;
          if (obs !== e.exp) begin
            errors++;
            $display("FAIL async_reset cyc%0d got %h exp %h", n, obs, e.exp);
          end
        end
      end
      if (pass == 0) begin
        din  = 4'h0;
        tick = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0))) begin
          errors++;
          $display("FAIL async_reset_now got %h exp %h", obs, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) push_period(4'b0000, 4'h0, 1'b1, ab(o4(0, 0, 0, 0), o4(0, 0, 0, 0)));
      end
    end
  endtask

  task automatic test_boundary();
    ent_t        e;
    int          n = 0;
    logic [33:0] z2;
    z2 = {o4(0, 0, 0, 0), o4(0, 0, 0, 0)};
    reset_c = 1'b1;
    push(1'b0, 4'h0, 4'h0, 1'b1, {z2, o8(8'hFF, 8'h00, 8'h00, 8'h00)});
    push(1'b1, 4'h0, 4'h0, 1'b1, {z2, o8(8'hFF, 8'h00, 8'h00, 8'h00)});
    push(1'b1, 4'h0, 4'h0, 1'b1, {z2, o8(8'h00, 8'h00, 8'hFF, 8'hFF)});
    push(1'b0, 4'h0, 4'h0, 1'b1, {z2, o8(8'h00, 8'h00, 8'h00, 8'hFF)});
    while (q.size() != 0) begin
      e = q.pop_front();
      tick = e.tick; din = e.din; clr = e.clr;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (e.chk) begin
        checks++;
        if (obs !== e.exp) begin
          errors++;
          $display("FAIL boundary cyc%0d got %h exp %h", n, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    reset_c = 1'b0;
    tick    = 1'b0;
    din     = 4'h0;
    clr     = 4'h0;
    din_c   = 8'h00;
    clr_c   = 8'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_clr_collision();
    test_async_reset();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
